// File: rtl/bcd_alu_seq_if.sv
// rtl/bcd_alu_seq_if.sv - request/response bundle between the keypad/display FSM and the BCD ALU
//
// Purpose: groups the start/busy/done handshake, operands and results of bcd_alu_seq.
// Parameter DIGITS sets the operand/result width W = 4*DIGITS (packed BCD, MSD in top nibble).
// Signals:
//   start  : request, sampled only while the ALU is idle
//   op     : 2'b10 = subtract, anything else = add
//   a_bcd  : operand A
//   b_bcd  : operand B
//   busy   : operation in flight (through the done cycle)
//   done   : one-cycle pulse, result/flags valid
//   result : packed BCD result, held until the next done
//   sat    : result saturated
//   err    : an input nibble was > 9
//   neg    : result is a negative magnitude (signed build only)
// Modports: master = requester side, slave = ALU side.
interface bcd_alu_seq_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [1:0]            op;
  logic [4*DIGITS-1:0]   a_bcd;
  logic [4*DIGITS-1:0]   b_bcd;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  sat;
  logic                  err;
  logic                  neg;

  modport master (
    output start, op, a_bcd, b_bcd,
    input  busy, done, result, sat, err, neg
  );

  modport slave (
    input  start, op, a_bcd, b_bcd,
    output busy, done, result, sat, err, neg
  );
endinterface

// File: rtl/bcd_alu_seq.sv
// rtl/bcd_alu_seq.sv - digit-serial saturating BCD add/subtract unit
//
// Purpose: adds or subtracts two DIGITS-digit packed BCD operands one decimal digit
// per clock, LSD first, with a decimal carry/borrow. Add overflow saturates to all
// nines, subtract underflow saturates to zero; operands with a nibble > 9 are flagged
// with err and produce a zero result.
// Optional macro BCD_ALU_SIGNED_EN: an underflowing subtraction is rerun as B - A and
// reported as a magnitude with neg = 1 instead of saturating.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset; abandons any operation without a done
//   bus : bcd_alu_seq_if.slave (start/op/a_bcd/b_bcd in; busy/done/result/sat/err/neg out)
module bcd_alu_seq #(
  parameter int DIGITS = 4
) (
  input logic          clk,
  input logic          rst,
  bcd_alu_seq_if.slave bus
);
  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
`ifdef BCD_ALU_SIGNED_EN
    ,SWAP  = 2'd3
`endif
  } state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [W-1:0]   acc;
  logic           sub_reg;
  logic           carry;
  logic           err_pend;
  logic [3:0]     idx;
`ifdef BCD_ALU_SIGNED_EN
  logic           swapped;
`endif

  logic [3:0]     a_dig;
  logic [3:0]     b_dig;
  logic [3:0]     dig;
  logic           cout;
  logic [4:0]     tmp;
  logic [W-1:0]   acc_next;
  logic           bad_in;

  // Select the operand digits addressed by idx.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) begin
        a_dig = a_reg[4*i +: 4];
        b_dig = b_reg[4*i +: 4];
      end
    end
  end

  // One decimal digit of add or subtract with carry/borrow in and out.
  always_comb begin
    tmp  = 5'd0;
    dig  = 4'd0;
    cout = 1'b0;
    if (sub_reg) begin
      tmp = {1'b0, b_dig} + {4'd0, carry};
      if ({1'b0, a_dig} < tmp) begin
        tmp  = ({1'b0, a_dig} + 5'd10) - tmp;
        cout = 1'b1;
      end else begin
        tmp  = {1'b0, a_dig} - tmp;
      end
      dig = tmp[3:0];
    end else begin
      tmp = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry};
      if (tmp > 5'd9) begin
        tmp  = tmp - 5'd10;
        cout = 1'b1;
      end
      dig = tmp[3:0];
    end
  end

  // Place the fresh digit at its own position in the accumulator.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) begin
        acc_next[4*i +: 4] = dig;
      end
    end
  end

  // Any non-decimal nibble in either operand on the input bus.
  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((bus.a_bcd[4*i +: 4] > 4'd9) || (bus.b_bcd[4*i +: 4] > 4'd9)) begin
        bad_in = 1'b1;
      end
    end
  end

`ifndef BCD_ALU_SIGNED_EN
  assign bus.neg = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      sub_reg    <= 1'b0;
      carry      <= 1'b0;
      err_pend   <= 1'b0;
      idx        <= 4'd0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.sat    <= 1'b0;
      bus.err    <= 1'b0;
`ifdef BCD_ALU_SIGNED_EN
      swapped    <= 1'b0;
      bus.neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // done/busy fall here unless a new request keeps busy asserted
          bus.done <= 1'b0;
          bus.busy <= bus.start;
          if (bus.start) begin
            a_reg    <= bus.a_bcd;
            b_reg    <= bus.b_bcd;
            sub_reg  <= (bus.op == 2'b10);
            idx      <= 4'd0;
            carry    <= 1'b0;
            acc      <= '0;
            err_pend <= bad_in;
`ifdef BCD_ALU_SIGNED_EN
            swapped  <= 1'b0;
`endif
            state    <= bad_in ? FINISH : CALC;
          end
        end

        CALC: begin
          acc   <= acc_next;
          carry <= cout;
          idx   <= idx + 4'd1;
          if (idx == LAST) begin
            state <= FINISH;
          end
        end

        FINISH: begin
`ifdef BCD_ALU_SIGNED_EN
          if (sub_reg && carry && !swapped && !err_pend) begin
            // A < B: no output yet, rerun as B - A
            state <= SWAP;
          end else begin
`endif
            bus.done <= 1'b1;
            state    <= IDLE;
            if (err_pend) begin
              bus.result <= '0;
              bus.sat    <= 1'b0;
              bus.err    <= 1'b1;
            end else if (carry) begin
              // unsigned overflow (add) or underflow (sub) saturates
              bus.result <= sub_reg ? '0 : {DIGITS{4'h9}};
              bus.sat    <= 1'b1;
              bus.err    <= 1'b0;
            end else begin
              bus.result <= acc;
              bus.sat    <= 1'b0;
              bus.err    <= 1'b0;
            end
`ifdef BCD_ALU_SIGNED_EN
            bus.neg <= swapped && !err_pend;
          end
`endif
        end

`ifdef BCD_ALU_SIGNED_EN
        SWAP: begin
          a_reg   <= b_reg;
          b_reg   <= a_reg;
          idx     <= 4'd0;
          carry   <= 1'b0;
          acc     <= '0;
          swapped <= 1'b1;
          state   <= CALC;
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end
endmodule
